id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage. It sits between decode and the execute-stage ALU, and drives the ALU's operand1, operand2, alu_op, alu_32, instruction and pc inputs directly.
- Resolves MEM/WB forwarding and detects load-use hazards.
- Refreshes held source values from writeback while stalled, so no forwarded result is lost during backpressure.

---
 rtl/id_ex_stage_if.sv | 84 ++++++++
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ALU opcode type and the decode/forwarding/execute bundle around the ID/EX stage.
// The stage owns the slave modport; the decode/execute environment owns master.
package enums_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } ALUop;
endpackage

interface id_ex_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    import enums_pkg::*;

    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [31:0]      id_instr;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [XLEN-1:0]  id_rs1_val;
    logic [XLEN-1:0]  id_rs2_val;
    logic [XLEN-1:0]  id_imm;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_use_pc;
    logic             id_use_imm;
    ALUop             id_alu_op;
    logic             id_alu_32;
    logic             id_reg_write;
    logic             flush;

    logic             mem_fwd_valid;
    logic [4:0]       mem_fwd_rd;
    logic [XLEN-1:0]  mem_fwd_data;
    logic             mem_is_load;
    logic             wb_fwd_valid;
    logic [4:0]       wb_fwd_rd;
    logic [XLEN-1:0]  wb_fwd_data;

    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  operand1;
    logic [XLEN-1:0]  operand2;
    ALUop             alu_op;
    logic             alu_32;
    logic [31:0]      instruction;
    logic [XLEN-1:0]  pc;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic [XLEN-1:0]  ex_store_data;
    logic             load_use_stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_pc, id_instr, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
               id_imm, id_uses_rs1, id_uses_rs2, id_use_pc, id_use_imm, id_alu_op,
               id_alu_32, id_reg_write, flush,
               mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_is_load,
               wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
        input  id_ready, ex_valid, operand1, operand2, alu_op, alu_32, instruction, pc,
               ex_rd, ex_reg_write, ex_store_data, load_use_stall, stall_count
    );

    modport slave (
        input  id_valid, id_pc, id_instr, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
               id_imm, id_uses_rs1, id_uses_rs2, id_use_pc, id_use_imm, id_alu_op,
               id_alu_32, id_reg_write, flush,
               mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_is_load,
               wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
        output id_ready, ex_valid, operand1, operand2, alu_op, alu_32, instruction, pc,
               ex_rd, ex_reg_write, ex_store_data, load_use_stall, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use hazard detection
// and writeback refresh of held source values while the instruction is stalled.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic  clk,
    input  logic  reset_n,
    id_ex_if.slave bus
);
    import enums_pkg::*;

    logic             r_held;
    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_instr;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_rs1_val;
    logic [XLEN-1:0]  r_rs2_val;
    logic [XLEN-1:0]  r_imm;
    logic             r_uses_rs1;
    logic             r_uses_rs2;
    logic             r_use_pc;
    logic             r_use_imm;
    ALUop             r_alu_op;
    logic             r_alu_32;
    logic             r_reg_write;
    logic [CNT_W-1:0] r_stall_count;

    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;
    logic             w_load_use;
    logic             w_ex_valid;
    logic             w_fire;
    logic             w_id_ready;
    logic             w_accept;
    logic             w_wb_hit_rs1;
    logic             w_wb_hit_rs2;

    // A load in MEM has no data yet, so it never forwards; it raises the hazard instead.
    always_comb begin
        w_fwd_rs1 = r_rs1_val;
        if (r_rs1 == 5'd0)
            w_fwd_rs1 = '0;
        else if (bus.mem_fwd_valid && !bus.mem_is_load && (bus.mem_fwd_rd == r_rs1))
            w_fwd_rs1 = bus.mem_fwd_data;
        else if (bus.wb_fwd_valid && (bus.wb_fwd_rd == r_rs1))
            w_fwd_rs1 = bus.wb_fwd_data;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_val;
        if (r_rs2 == 5'd0)
            w_fwd_rs2 = '0;
        else if (bus.mem_fwd_valid && !bus.mem_is_load && (bus.mem_fwd_rd == r_rs2))
            w_fwd_rs2 = bus.mem_fwd_data;
        else if (bus.wb_fwd_valid && (bus.wb_fwd_rd == r_rs2))
            w_fwd_rs2 = bus.wb_fwd_data;
    end

    assign w_load_use = r_held && bus.mem_fwd_valid && bus.mem_is_load &&
                        (bus.mem_fwd_rd != 5'd0) &&
                        ((r_uses_rs1 && (bus.mem_fwd_rd == r_rs1)) ||
                         (r_uses_rs2 && (bus.mem_fwd_rd == r_rs2)));
    assign w_ex_valid = r_held && !w_load_use;
    assign w_fire     = w_ex_valid && bus.ex_ready;
    assign w_id_ready = !r_held || w_fire;
    assign w_accept   = bus.id_valid && w_id_ready && !bus.flush;

    assign w_wb_hit_rs1 = bus.wb_fwd_valid && (bus.wb_fwd_rd != 5'd0) && (bus.wb_fwd_rd == r_rs1);
    assign w_wb_hit_rs2 = bus.wb_fwd_valid && (bus.wb_fwd_rd != 5'd0) && (bus.wb_fwd_rd == r_rs2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_held      <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_uses_rs1  <= 1'b0;
            r_uses_rs2  <= 1'b0;
            r_use_pc    <= 1'b0;
            r_use_imm   <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_alu_32    <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (bus.flush) begin
            r_held <= 1'b0;
        end else if (w_accept) begin
            r_held      <= 1'b1;
            r_pc        <= bus.id_pc;
            r_instr     <= bus.id_instr;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_rs1_val   <= bus.id_rs1_val;
            r_rs2_val   <= bus.id_rs2_val;
            r_imm       <= bus.id_imm;
            r_uses_rs1  <= bus.id_uses_rs1;
            r_uses_rs2  <= bus.id_uses_rs2;
            r_use_pc    <= bus.id_use_pc;
            r_use_imm   <= bus.id_use_imm;
            r_alu_op    <= bus.id_alu_op;
            r_alu_32    <= bus.id_alu_32;
            r_reg_write <= bus.id_reg_write;
        end else if (w_fire) begin
            r_held <= 1'b0;
        end else if (r_held) begin
            // Capture retiring producers so the value survives after WB moves on.
            if (w_wb_hit_rs1)
                r_rs1_val <= bus.wb_fwd_data;
            if (w_wb_hit_rs2)
                r_rs2_val <= bus.wb_fwd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall_count <= '0;
        else if (r_held && !w_fire && !bus.flush && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    assign bus.id_ready       = w_id_ready;
    assign bus.ex_valid       = w_ex_valid;
    assign bus.load_use_stall = w_load_use;
    assign bus.operand1       = r_use_pc  ? r_pc  : w_fwd_rs1;
    assign bus.operand2       = r_use_imm ? r_imm : w_fwd_rs2;
    assign bus.ex_store_data  = w_fwd_rs2;
    assign bus.alu_op         = r_alu_op;
    assign bus.alu_32         = r_alu_32;
    assign bus.instruction    = r_instr;
    assign bus.pc             = r_pc;
    assign bus.ex_rd          = r_rd;
    assign bus.ex_reg_write   = r_reg_write;
    assign bus.stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-instruction forwarding/hazard
// vectors followed by hand-written multi-cycle sequences.
module tb_id_ex_stage;
    import enums_pkg::*;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    id_ex_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [63:0] rs1_val, rs2_val, imm, pc;
        logic        uses1, uses2, use_pc, use_imm;
        logic        mv;
        logic [4:0]  mrd;
        logic [63:0] mdata;
        logic        mload;
        logic        wv;
        logic [4:0]  wrd;
        logic [63:0] wdata;
        logic [63:0] e_op1, e_op2, e_st;
        logic        e_lus, e_v;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid      = 1'b0;
        bus.id_pc         = '0;
        bus.id_instr      = '0;
        bus.id_rs1        = '0;
        bus.id_rs2        = '0;
        bus.id_rd         = '0;
        bus.id_rs1_val    = '0;
        bus.id_rs2_val    = '0;
        bus.id_imm        = '0;
        bus.id_uses_rs1   = 1'b0;
        bus.id_uses_rs2   = 1'b0;
        bus.id_use_pc     = 1'b0;
        bus.id_use_imm    = 1'b0;
        bus.id_alu_op     = ALU_ADD;
        bus.id_alu_32     = 1'b0;
        bus.id_reg_write  = 1'b0;
        bus.flush         = 1'b0;
        bus.ex_ready      = 1'b0;
        fwd_idle();
    endtask

    task automatic fwd_idle();
        bus.mem_fwd_valid = 1'b0;
        bus.mem_fwd_rd    = '0;
        bus.mem_fwd_data  = '0;
        bus.mem_is_load   = 1'b0;
        bus.wb_fwd_valid  = 1'b0;
        bus.wb_fwd_rd     = '0;
        bus.wb_fwd_data   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Presents one instruction on the decode side (left valid for the caller to drop).
    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] imm,
                           input logic [63:0] pcv, input logic [31:0] ins,
                           input logic u1, input logic u2, input logic upc, input logic uimm);
        bus.id_valid    = 1'b1;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_val  = v1;
        bus.id_rs2_val  = v2;
        bus.id_imm      = imm;
        bus.id_pc       = pcv;
        bus.id_instr    = ins;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_use_pc   = upc;
        bus.id_use_imm  = uimm;
        bus.id_reg_write = 1'b1;
    endtask

    initial begin
        vt[0] = '{5'd1, 5'd2, 64'h11, 64'h22, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0,
                  64'h11, 64'h22, 64'h22, 1'b0, 1'b1};
        vt[1] = '{5'd1, 5'd2, 64'h11, 64'h22, 64'hFFFF_FFFF_FFFF_FFF0, 64'h2000, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0,
                  64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h22, 1'b0, 1'b1};
        vt[2] = '{5'd3, 5'd2, 64'h33, 64'h22, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b1, 5'd3, 64'hAA, 1'b0, 1'b1, 5'd3, 64'hBB,
                  64'hAA, 64'h22, 64'h22, 1'b0, 1'b1};
        vt[3] = '{5'd1, 5'd4, 64'h11, 64'h44, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 5'd4, 64'hBB,
                  64'h11, 64'hBB, 64'hBB, 1'b0, 1'b1};
        vt[4] = '{5'd0, 5'd2, 64'h99, 64'h22, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b1, 5'd0, 64'h77, 1'b0, 1'b1, 5'd0, 64'h66,
                  64'h0, 64'h22, 64'h22, 1'b0, 1'b1};
        vt[5] = '{5'd4, 5'd2, 64'h44, 64'h22, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b1, 5'd4, 64'hDEAD, 1'b1, 1'b0, 5'd0, 64'h0,
                  64'h44, 64'h22, 64'h22, 1'b1, 1'b0};
        vt[6] = '{5'd1, 5'd5, 64'h11, 64'h55, 64'h10, 64'h1000, 1'b1, 1'b0, 1'b0, 1'b0,
                  1'b1, 5'd5, 64'h9, 1'b1, 1'b0, 5'd0, 64'h0,
                  64'h11, 64'h55, 64'h55, 1'b0, 1'b1};
        vt[7] = '{5'd0, 5'd0, 64'h3, 64'h4, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b1, 5'd0, 64'h0, 1'b1, 1'b0, 5'd0, 64'h0,
                  64'h0, 64'h0, 64'h0, 1'b0, 1'b1};
        vt[8] = '{5'd5, 5'd6, 64'h1, 64'h2, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b1, 5'd6, 64'h7, 1'b1, 1'b1, 5'd6, 64'h1234,
                  64'h1, 64'h1234, 64'h1234, 1'b1, 1'b0};
        vt[9] = '{5'd1, 5'd2, 64'h11, 64'h22, 64'h10, 64'h1000, 1'b1, 1'b1, 1'b0, 1'b1,
                  1'b1, 5'd2, 64'hCC, 1'b0, 1'b0, 5'd0, 64'h0,
                  64'h11, 64'h10, 64'hCC, 1'b0, 1'b1};

        reset_n = 1'b1;
        idle();
        do_reset();

        // Reset state
        chk("rst_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("rst_id_ready", {63'd0, bus.id_ready}, 64'd1);
        chk("rst_lus", {63'd0, bus.load_use_stall}, 64'd0);
        chk("rst_stall_count", 64'(bus.stall_count), 64'd0);
        chk("rst_alu_op", 64'(bus.alu_op), 64'(ALU_ADD));

        // Table vectors: accept, then present forwarding state and check the outputs
        for (int i = 0; i < 10; i++) begin
            present(vt[i].rs1, vt[i].rs2, 5'd9, vt[i].rs1_val, vt[i].rs2_val, vt[i].imm,
                    vt[i].pc, 32'h0000_0013, vt[i].uses1, vt[i].uses2, vt[i].use_pc, vt[i].use_imm);
            tick();
            bus.id_valid      = 1'b0;
            bus.ex_ready      = 1'b1;
            bus.mem_fwd_valid = vt[i].mv;
            bus.mem_fwd_rd    = vt[i].mrd;
            bus.mem_fwd_data  = vt[i].mdata;
            bus.mem_is_load   = vt[i].mload;
            bus.wb_fwd_valid  = vt[i].wv;
            bus.wb_fwd_rd     = vt[i].wrd;
            bus.wb_fwd_data   = vt[i].wdata;
            #1;
            chk($sformatf("v%0d_op1", i), bus.operand1, vt[i].e_op1);
            chk($sformatf("v%0d_op2", i), bus.operand2, vt[i].e_op2);
            chk($sformatf("v%0d_store", i), bus.ex_store_data, vt[i].e_st);
            chk($sformatf("v%0d_lus", i), {63'd0, bus.load_use_stall}, {63'd0, vt[i].e_lus});
            chk($sformatf("v%0d_ex_valid", i), {63'd0, bus.ex_valid}, {63'd0, vt[i].e_v});
            fwd_idle();
            bus.ex_ready = 1'b0;
            bus.flush    = 1'b1;
            tick();
            bus.flush    = 1'b0;
        end

        // Back-to-back ADDI x1,x0,5 ; ADD x2,x1,x1 with MEM forwarding x1
        do_reset();
        present(5'd0, 5'd0, 5'd1, 64'h0, 64'h0, 64'd5, 64'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.ex_ready = 1'b1;
        #1;
        chk("b2b_ready0", {63'd0, bus.id_ready}, 64'd1);
        tick();
        present(5'd1, 5'd1, 5'd2, 64'h0, 64'h0, 64'h0, 64'h104, 32'h0010_8133, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("b2b_v1", {63'd0, bus.ex_valid}, 64'd1);
        chk("b2b_op1_first", bus.operand1, 64'd0);
        chk("b2b_op2_first", bus.operand2, 64'd5);
        chk("b2b_ready1", {63'd0, bus.id_ready}, 64'd1);
        tick();
        bus.id_valid      = 1'b0;
        bus.mem_fwd_valid = 1'b1;
        bus.mem_fwd_rd    = 5'd1;
        bus.mem_fwd_data  = 64'd5;
        #1;
        chk("b2b_v2", {63'd0, bus.ex_valid}, 64'd1);
        chk("b2b_op1", bus.operand1, 64'd5);
        chk("b2b_op2", bus.operand2, 64'd5);
        chk("b2b_instr", 64'(bus.instruction), 64'h0010_8133);
        chk("b2b_pc", bus.pc, 64'h104);
        chk("b2b_rd", 64'(bus.ex_rd), 64'd2);
        tick();
        fwd_idle();
        #1;
        chk("b2b_drain", {63'd0, bus.ex_valid}, 64'd0);

        // Load-use: LD x4 in MEM, then WB forwards 0x1234
        do_reset();
        present(5'd4, 5'd0, 5'd5, 64'h0, 64'h0, 64'd8, 64'h200, 32'h0082_0293, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.id_valid      = 1'b0;
        bus.ex_ready      = 1'b1;
        bus.mem_fwd_valid = 1'b1;
        bus.mem_fwd_rd    = 5'd4;
        bus.mem_is_load   = 1'b1;
        #1;
        chk("lu_stall", {63'd0, bus.load_use_stall}, 64'd1);
        chk("lu_ex_valid0", {63'd0, bus.ex_valid}, 64'd0);
        tick();
        fwd_idle();
        bus.wb_fwd_valid = 1'b1;
        bus.wb_fwd_rd    = 5'd4;
        bus.wb_fwd_data  = 64'h1234;
        #1;
        chk("lu_stall_clear", {63'd0, bus.load_use_stall}, 64'd0);
        chk("lu_ex_valid1", {63'd0, bus.ex_valid}, 64'd1);
        chk("lu_op1", bus.operand1, 64'h1234);
        chk("lu_stall_count", 64'(bus.stall_count), 64'd1);
        tick();
        fwd_idle();
        #1;
        chk("lu_drain", {63'd0, bus.ex_valid}, 64'd0);

        // Backpressure 3 cycles with WB refresh of rs2 on the first
        do_reset();
        present(5'd1, 5'd5, 5'd0, 64'h10, 64'h0, 64'h8, 64'h300, 32'h0050_b423, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        bus.id_valid     = 1'b0;
        bus.wb_fwd_valid = 1'b1;
        bus.wb_fwd_rd    = 5'd5;
        bus.wb_fwd_data  = 64'h55;
        tick();
        bus.wb_fwd_rd    = 5'd7;
        bus.wb_fwd_data  = 64'h77;
        tick();
        fwd_idle();
        tick();
        bus.ex_ready = 1'b1;
        #1;
        chk("bp_ex_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("bp_store", bus.ex_store_data, 64'h55);
        chk("bp_stall_count", 64'(bus.stall_count), 64'd3);
        tick();
        #1;
        chk("bp_drain", {63'd0, bus.ex_valid}, 64'd0);
        chk("bp_count_hold", 64'(bus.stall_count), 64'd3);

        // stall_count saturation
        do_reset();
        present(5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0, 64'h400, 32'h0020_81b3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        repeat (20) tick();
        chk("sat_count", 64'(bus.stall_count), 64'd15);
        chk("sat_ex_valid", {63'd0, bus.ex_valid}, 64'd1);

        // Flush with a simultaneous incoming instruction
        do_reset();
        present(5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0, 64'h3000, 32'h1111_1113, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.id_alu_op = ALU_XOR;
        tick();
        present(5'd6, 5'd7, 5'd8, 64'h6, 64'h7, 64'h0, 64'h4000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.id_alu_op = ALU_SUB;
        bus.flush     = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b1;
        #1;
        chk("fl_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("fl_id_ready", {63'd0, bus.id_ready}, 64'd1);
        chk("fl_pc", bus.pc, 64'h3000);
        chk("fl_instr", 64'(bus.instruction), 64'h1111_1113);
        chk("fl_alu_op", 64'(bus.alu_op), 64'(ALU_XOR));
        chk("fl_stall_count", 64'(bus.stall_count), 64'd0);
        tick();
        tick();
        chk("fl_ex_valid_later", {63'd0, bus.ex_valid}, 64'd0);

        // Asynchronous reset while an instruction is held and stalled
        do_reset();
        present(5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0, 64'h500, 32'h0020_81b3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        tick();
        tick();
        chk("ar_pre_count", 64'(bus.stall_count), 64'd2);
        chk("ar_pre_valid", {63'd0, bus.ex_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("ar_id_ready", {63'd0, bus.id_ready}, 64'd1);
        chk("ar_stall_count", 64'(bus.stall_count), 64'd0);
        chk("ar_lus", {63'd0, bus.load_use_stall}, 64'd0);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
